// File: rtl/airlock_sequencer.sv
// -----------------------------------------------------------------------------
// airlock_sequencer
//
// Sequences the three-phase lock cycle (Arrive -> Fill-and-Pump -> Evacuate)
// and produces the per-phase counters for the seven-segment display decoder.
// Counting is paced by a one-cycle timebase strobe from the clock divider.
//
// Parameters:
//   ARRIVE_MAX  final countArrive value   (1..7)
//   FANDP_MAX   final countFandP value    (1..7)
//   EVAC_MAX    final countEvacuate value (1..15)
//
// Ports:
//   Clock          in   system clock, rising-edge
//   Reset          in   asynchronous, active-high
//   tick           in   timebase strobe, one Clock cycle per time unit
//   arrive_req     in   starts a cycle (honoured only in IDLE)
//   evac_req       in   releases Evacuate (honoured only in WAIT_EVAC)
//   hold           in   masks tick while high
//   countArrive    out  [2:0] Arrive phase count
//   countFandP     out  [2:0] Fill-and-Pump phase count
//   countEvacuate  out  [3:0] Evacuate phase count
//   phase          out  [2:0] 0=IDLE 1=ARRIVE 2=FANDP 3=WAIT_EVAC 4=EVACUATE
//   busy           out  high whenever phase != IDLE
//   done           out  one-cycle pulse after EVACUATE completes
// -----------------------------------------------------------------------------
module airlock_sequencer #(
  parameter int ARRIVE_MAX = 4,
  parameter int FANDP_MAX  = 7,
  parameter int EVAC_MAX   = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       arrive_req,
  input  logic       evac_req,
  input  logic       hold,
  output logic [2:0] countArrive,
  output logic [2:0] countFandP,
  output logic [3:0] countEvacuate,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARRIVE    = 3'd1,
    S_FANDP     = 3'd2,
    S_WAIT_EVAC = 3'd3,
    S_EVACUATE  = 3'd4
  } state_t;

  localparam logic [2:0] A_MAX = 3'(ARRIVE_MAX);
  localparam logic [2:0] F_MAX = 3'(FANDP_MAX);
  localparam logic [3:0] E_MAX = 4'(EVAC_MAX);

  state_t     state_q;
  logic [2:0] cnt_arrive_q;
  logic [2:0] cnt_fandp_q;
  logic [3:0] cnt_evac_q;
  logic       busy_q;
  logic       done_q;

  // Only an unmasked strobe moves counters or ends a timed phase.
  logic etick;
  assign etick = tick & ~hold;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_arrive_q <= '0;
      cnt_fandp_q  <= '0;
      cnt_evac_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Counts from the previous cycle stay visible until a new request.
          // A tick in the request cycle is deliberately not counted.
          if (arrive_req) begin
            state_q      <= S_ARRIVE;
            cnt_arrive_q <= '0;
            cnt_fandp_q  <= '0;
            cnt_evac_q   <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_ARRIVE: begin
          // Phase spans MAX+1 effective ticks: the count shows 0..MAX and the
          // tick that finds it at MAX hands over to the next phase.
          if (etick) begin
            if (cnt_arrive_q == A_MAX) state_q <= S_FANDP;
            else                       cnt_arrive_q <= cnt_arrive_q + 3'd1;
          end
        end
        S_FANDP: begin
          if (etick) begin
            if (cnt_fandp_q == F_MAX) state_q <= S_WAIT_EVAC;
            else                      cnt_fandp_q <= cnt_fandp_q + 3'd1;
          end
        end
        S_WAIT_EVAC: begin
          // Release is untimed, so hold has no effect here.
          if (evac_req) state_q <= S_EVACUATE;
        end
        S_EVACUATE: begin
          if (etick) begin
            if (cnt_evac_q == E_MAX) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_evac_q <= cnt_evac_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign countArrive   = cnt_arrive_q;
  assign countFandP    = cnt_fandp_q;
  assign countEvacuate = cnt_evac_q;
  assign phase         = state_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
module tb_airlock_sequencer;

  localparam int ARRIVE_MAX = 4;
  localparam int FANDP_MAX  = 7;
  localparam int EVAC_MAX   = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       tick = 1'b0, arrive_req = 1'b0, evac_req = 1'b0, hold = 1'b0;
  logic [2:0] countArrive, countFandP, phase;
  logic [3:0] countEvacuate;
  logic       busy, done;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  airlock_sequencer #(
    .ARRIVE_MAX(ARRIVE_MAX), .FANDP_MAX(FANDP_MAX), .EVAC_MAX(EVAC_MAX)
  ) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick), .arrive_req(arrive_req),
    .evac_req(evac_req), .hold(hold), .countArrive(countArrive),
    .countFandP(countFandP), .countEvacuate(countEvacuate), .phase(phase),
    .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;

  // Parameter legality, evaluated before any stimulus.
  initial begin
    if (ARRIVE_MAX < 1 || ARRIVE_MAX > 7 || FANDP_MAX < 1 || FANDP_MAX > 7 ||
        EVAC_MAX < 1 || EVAC_MAX > 15) begin
      $display("FAIL param_range: got %0d/%0d/%0d required within 1..7/1..7/1..15",
               ARRIVE_MAX, FANDP_MAX, EVAC_MAX);
      $fatal(1, "illegal parameters");
    end
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int ph, input int ca,
                         input int cf, input int ce, input int b, input int d);
    chk({name, ".phase"}, int'(phase), ph);
    chk({name, ".countArrive"}, int'(countArrive), ca);
    chk({name, ".countFandP"}, int'(countFandP), cf);
    chk({name, ".countEvacuate"}, int'(countEvacuate), ce);
    chk({name, ".busy"}, int'(busy), b);
    chk({name, ".done"}, int'(done), d);
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge, then drop
  // the inputs so tick stays a single-cycle strobe.
  task automatic cyc(input logic t, input logic a, input logic e, input logic h);
    @(negedge Clock);
    tick = t; arrive_req = a; evac_req = e; hold = h;
    @(posedge Clock);
    #1;
    if (done) done_seen++;
    tick = 1'b0; arrive_req = 1'b0; evac_req = 1'b0; hold = 1'b0;
  endtask

  // Tick every fourth clock.
  task automatic slow_tick(input logic e);
    repeat (3) cyc(1'b0, 1'b0, e, 1'b0);
    cyc(1'b1, 1'b0, e, 1'b0);
  endtask

  typedef struct {
    logic t, a, e, h;
    int   ph, ca, cf, ce, b, d;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic t, input logic a, input logic e,
                              input logic h, input int ph, input int ca,
                              input int cf, input int ce, input int b, input int d);
    vec_t v;
    v.t = t; v.a = a; v.e = e; v.h = h;
    v.ph = ph; v.ca = ca; v.cf = cf; v.ce = ce; v.b = b; v.d = d;
    return v;
  endfunction

  initial begin
    //              t  a  e  h   ph ca cf ce b  d
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // idle after reset
    vecs[1]  = mk(0, 0, 1, 0,  0, 0, 0, 0, 0, 0); // evac alone ignored
    vecs[2]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0); // tick alone in idle
    vecs[3]  = mk(1, 1, 1, 0,  1, 0, 0, 0, 1, 0); // arrive wins, tick not counted
    vecs[4]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0,  1, 1, 0, 0, 1, 0); // first increment
    vecs[6]  = mk(1, 0, 1, 0,  1, 2, 0, 0, 1, 0); // evac in ARRIVE ignored
    vecs[7]  = mk(1, 0, 0, 1,  1, 2, 0, 0, 1, 0); // hold x3 at 2
    vecs[8]  = mk(1, 0, 0, 1,  1, 2, 0, 0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 1,  1, 2, 0, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 0,  1, 2, 0, 0, 1, 0);
    vecs[11] = mk(1, 0, 0, 0,  1, 3, 0, 0, 1, 0); // released -> 3
    vecs[12] = mk(0, 1, 0, 0,  1, 3, 0, 0, 1, 0); // arrive in ARRIVE ignored
    vecs[13] = mk(1, 0, 0, 0,  1, 4, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 1, 0,  1, 4, 0, 0, 1, 0);
    vecs[15] = mk(1, 0, 0, 0,  2, 4, 0, 0, 1, 0); // 5th effective tick ends ARRIVE
    vecs[16] = mk(1, 0, 1, 0,  2, 4, 1, 0, 1, 0); // evac in FANDP ignored

    // Reset held across a few edges.
    repeat (3) @(posedge Clock);
    #1;
    chk_all("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].t, vecs[i].a, vecs[i].e, vecs[i].h);
      chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ca, vecs[i].cf,
              vecs[i].ce, vecs[i].b, vecs[i].d);
      $display("vec %0d: phase=%0d A=%0d F=%0d E=%0d busy=%0d done=%0d", i,
               phase, countArrive, countFandP, countEvacuate, busy, done);
    end

    // Finish FANDP with evac pulses on non-tick cycles.
    for (int i = 2; i <= 7; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("fandp_count%0d", i), int'(countFandP), i);
    end
    chk("fandp_phase_before_end", int'(phase), 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("enter_wait", 3, 4, 7, 0, 1, 0);
    $display("seq fandp_to_wait: phase=%0d", phase);

    // 50 clocks in WAIT_EVAC with evac low: ticks and hold do nothing.
    for (int i = 0; i < 50; i++) begin
      cyc((i % 5) == 0, 1'b0, 1'b0, (i % 2) == 1);
      chk_all($sformatf("wait_frozen%0d", i), 3, 4, 7, 0, 1, 0);
    end
    $display("seq wait_frozen: phase=%0d", phase);

    // evac under hold still releases; coincident tick not counted.
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk_all("evac_under_hold", 4, 4, 7, 0, 1, 0);

    // arrive_req during EVACUATE is ignored.
    done_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("evac_arrive_ign%0d", i), int'(phase), 4);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("evac_count%0d", i), int'(countEvacuate), i);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("evac_complete", 0, 4, 7, 8, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("done_one_cycle", 0, 4, 7, 8, 0, 0);
    chk("done_pulses_a", done_seen, 1);
    $display("seq evacuate: done pulses=%0d", done_seen);

    // Nominal cycle, tick every 4 clocks.
    done_seen = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("nom_entry", 1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      slow_tick(1'b0);
      chk($sformatf("nom_arrive%0d", i), int'(countArrive), i);
      chk($sformatf("nom_arrive_ph%0d", i), int'(phase), 1);
    end
    slow_tick(1'b0);
    chk_all("nom_fandp_entry", 2, 4, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      slow_tick(1'b0);
      chk($sformatf("nom_fandp%0d", i), int'(countFandP), i);
      chk($sformatf("nom_fandp_ph%0d", i), int'(phase), 2);
    end
    slow_tick(1'b0);
    chk_all("nom_wait_entry", 3, 4, 7, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc((i % 4) == 3, 1'b0, 1'b0, 1'b0);
    end
    chk_all("nom_wait_hold", 3, 4, 7, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_all("nom_evac_entry", 4, 4, 7, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      slow_tick(1'b0);
      chk($sformatf("nom_evac%0d", i), int'(countEvacuate), i);
      chk($sformatf("nom_evac_ph%0d", i), int'(phase), 4);
    end
    slow_tick(1'b0);
    chk_all("nom_done", 0, 4, 7, 8, 0, 1);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("nom_idle_held", 0, 4, 7, 8, 0, 0);
    chk("nom_done_pulses", done_seen, 1);
    $display("seq nominal: done pulses=%0d", done_seen);

    // New request clears the held counts.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("rearm_clear", 1, 0, 0, 0, 1, 0);

    // Reach FANDP count 3, then reset between edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("pre_reset", 2, 4, 3, 0, 1, 0);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    $display("seq async_reset: phase=%0d busy=%0d", phase, busy);
    @(negedge Clock);
    Reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk_all("post_reset_idle", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_all("post_reset_arrive", 1, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
